// File: rtl/fir_stream_pipe.sv
// fir_stream_pipe: pipelined streaming FIR filter with runtime-programmable taps.
//
// Build option: define FIR_SAT_EN to clamp the result to 2^RES_W-1. Without it,
// the result wraps: the bits of the full sum above RES_W are discarded.
// Latency is the same in both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous flush of delay line and valid pipeline
//   coef_we    in   coefficient write strobe
//   coef_addr  in   tap index to write (indices >= TAPS are ignored)
//   coef_data  in   coefficient value
//   in_valid   in   sample strobe
//   in_data    in   sample
//   out_valid  out  one-cycle result strobe per accepted sample
//   out_data   out  filter result
//
// A sample accepted at edge E appears at edge E+2+clog2(TAPS):
//   - edge E: the sample enters the delay line.
//   - edge E+1: the products are registered.
//   - edges E+2 .. E+1+L: one register per adder-tree level.
//   - edge E+2+L: the output register is loaded.
module fir_stream_pipe #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int RES_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [RES_W-1:0]         out_data
);

  localparam int L      = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int FULL_W = PROD_W + L;
  localparam int VLD_D  = 2 + L;

  // Number of live partial sums after `lvl` tree levels (level 0 = products).
  function automatic int lvl_cnt(input int lvl);
    return (TAPS + (1 << lvl) - 1) >> lvl;
  endfunction

  logic [DATA_W-1:0] x_q [TAPS];
  logic [DATA_W-1:0] x_d [TAPS];
  logic [COEF_W-1:0] c_q [TAPS];
  logic [COEF_W-1:0] c_d [TAPS];
  logic [PROD_W-1:0] p_q [TAPS];
  logic [PROD_W-1:0] p_d [TAPS];
  // Tree level n is stored in t_q[n-1]. Slots beyond lvl_cnt(n) stay zero.
  logic [FULL_W-1:0] t_q [L][TAPS];
  logic [FULL_W-1:0] t_d [L][TAPS];
  logic [FULL_W-1:0] src [L+1][TAPS];
  logic [VLD_D-1:0]  vld_q, vld_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;
  logic [FULL_W-1:0] sum;

  always_comb begin
    x_d = x_q;
    c_d = c_q;
    if (coef_we && (int'(coef_addr) < TAPS)) c_d[coef_addr] = coef_data;
    if (clr) begin
      for (int k = 0; k < TAPS; k++) x_d[k] = '0;
    end else if (in_valid) begin
      x_d[0] = in_data;
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end
    // clr also clears the stage about to reach the output, so a flushed result
    // never pulses out_valid.
    vld_d       = clr ? '0 : {vld_q[VLD_D-2:0], in_valid};
    out_valid_d = clr ? 1'b0 : vld_q[VLD_D-1];
  end

  // Products use the coefficient already registered when the sample entered
  // the delay line. A write on the accept edge therefore applies to that sample.
  always_comb begin
    for (int k = 0; k < TAPS; k++) p_d[k] = PROD_W'(x_q[k]) * PROD_W'(c_q[k]);
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) src[0][k] = FULL_W'(p_q[k]);
    for (int lvl = 1; lvl <= L; lvl++) begin
      for (int k = 0; k < TAPS; k++) src[lvl][k] = t_q[lvl-1][k];
    end
  end

  // Each level adds adjacent pairs. An unpaired last element is registered
  // unchanged, so every path has the same depth.
  always_comb begin
    for (int lvl = 0; lvl < L; lvl++) begin
      for (int i = 0; i < TAPS; i++) begin
        t_d[lvl][i] = '0;
        if (i < lvl_cnt(lvl + 1)) begin
          t_d[lvl][i] = src[lvl][2*i];
          if (2*i + 1 < lvl_cnt(lvl)) t_d[lvl][i] = src[lvl][2*i] + src[lvl][2*i+1];
        end
      end
    end
  end

  assign sum = t_q[L-1][0];

  always_comb begin
`ifdef FIR_SAT_EN
    out_data_d = (sum > FULL_W'({RES_W{1'b1}})) ? {RES_W{1'b1}} : RES_W'(sum);
`else
    out_data_d = RES_W'(sum);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      p_q         <= '{default: '0};
      t_q         <= '{default: '{default: '0}};
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      c_q         <= c_d;
      p_q         <= p_d;
      t_q         <= t_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_stream_pipe.sv
// tb_fir_stream_pipe: self-checking bench for fir_stream_pipe with the
// default parameters (10 taps, 8-bit data and coefficients, 16-bit result).
//
// The reference model keeps two things:
//   - the last TAPS accepted samples;
//   - the current coefficient set.
// For each accepted sample it computes the dot product with plain arithmetic.
// The result is scheduled to appear LAT cycles after the accept edge.
module tb_fir_stream_pipe;

  localparam int TAPS = 10;
  localparam int LAT  = 6;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [15:0] out_data;

  fir_stream_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   ref_coef [TAPS];
  int   ref_hist [TAPS];
  exp_t pend [$];
  bit   exp_v;
  int   exp_d;
  int   got [$];
  int   stream [10] = '{0, 16, 8, 4, 14, 12, 18, 3, 5, 6};

  function automatic int fix(input longint s);
`ifdef FIR_SAT_EN
    return (s > 65535) ? 65535 : int'(s);
`else
    return int'(s % 65536);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      ref_coef[k] = 0;
      ref_hist[k] = 0;
    end
    pend.delete();
    exp_v = 1'b0;
  endtask

  // Drive one cycle of inputs and advance the model across the edge.
  // Afterwards exp_v/exp_d hold the output expected just after that edge.
  task automatic tick(input bit v, input int d, input bit c, input bit we,
                      input int addr, input int cd);
    in_valid  = v;
    in_data   = 8'(d);
    clr       = c;
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = 8'(cd);
    @(posedge clk);
    cyc++;
    if (we && addr < TAPS) ref_coef[addr] = cd;
    exp_v = 1'b0;
    if (c) begin
      pend.delete();
      for (int k = 0; k < TAPS; k++) ref_hist[k] = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_v = 1'b1;
        exp_d = pend[0].val;
        void'(pend.pop_front());
      end
      if (v) begin
        longint s = 0;
        for (int k = TAPS - 1; k > 0; k--) ref_hist[k] = ref_hist[k-1];
        ref_hist[0] = d;
        for (int k = 0; k < TAPS; k++) s += longint'(ref_coef[k]) * longint'(ref_hist[k]);
        pend.push_back('{cyc + LAT, fix(s)});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b out_data=%0d expected 0/0", out_valid, out_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d out_valid=%b expected 0", cyc, out_valid);
      end
    end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < TAPS; k++) tick(0, 0, 0, 1, k, k + 1);
    tick(0, 0, 1, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 18; i++) begin
      tick(i < 10, (i == 0) ? 1 : 0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL impulse_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== 16'(exp_d)) begin
          errors++;
          $display("FAIL impulse_data cyc=%0d out_data=%0d expected %0d", cyc, out_data, exp_d);
        end
      end
      // First accept is on tick 0, so its result is due on tick LAT.
      if (out_valid === 1'b1) got.push_back(int'(out_data));
      if (i == LAT) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL impulse_latency cyc=%0d out_valid=%b expected 1", cyc, out_valid);
        end
      end
    end
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL impulse_count got %0d results expected 10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] != i + 1) begin
          errors++;
          $display("FAIL impulse_seq index %0d got %0d expected %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_moving_sum(input bit gapped);
    int n;
    int last;
    for (int k = 0; k < TAPS; k++) tick(0, 0, 0, 1, k, 1);
    tick(0, 0, 1, 0, 0, 0);
    got.delete();
    n = gapped ? 20 : 10;
    for (int i = 0; i < n + 8; i++) begin
      bit v;
      int d;
      v = (i < n) && (!gapped || (i % 2 == 0));
      d = (i < n) ? stream[gapped ? i / 2 : i] : 0;
      tick(v, d, 0, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL movsum_valid gapped=%0d cyc=%0d out_valid=%b expected %b", gapped, cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== 16'(exp_d)) begin
          errors++;
          $display("FAIL movsum_data gapped=%0d cyc=%0d out_data=%0d expected %0d", gapped, cyc, out_data, exp_d);
        end
      end
      if (out_valid === 1'b1) got.push_back(int'(out_data));
    end
    checks++;
    last = (got.size() == 10) ? got[9] : -1;
    if (got.size() != 10 || last != 86 || got[1] != 16 || got[2] != 24 || got[3] != 28) begin
      errors++;
      $display("FAIL movsum_final gapped=%0d count=%0d last=%0d expected 10 results ending 86", gapped, got.size(), last);
    end
  endtask

  task automatic test_overflow();
    int last;
    int want;
`ifdef FIR_SAT_EN
    want = 65535;
`else
    want = 60426;
`endif
    for (int k = 0; k < TAPS; k++) tick(0, 0, 0, 1, k, 255);
    tick(0, 0, 1, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 18; i++) begin
      tick(i < 10, 255, 0, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL overflow_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== 16'(exp_d)) begin
          errors++;
          $display("FAIL overflow_data cyc=%0d out_data=%0d expected %0d", cyc, out_data, exp_d);
        end
      end
      if (out_valid === 1'b1) got.push_back(int'(out_data));
    end
    last = (got.size() == 10) ? got[9] : -1;
    checks++;
    if (last != want) begin
      errors++;
      $display("FAIL overflow_final got %0d expected %0d", last, want);
    end
  endtask

  task automatic test_clr_coef();
    // Samples in flight, then a flush: none of them may emerge.
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(i < 3, 10 + i, i == 5, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL clr_discard cyc=%0d out_valid=%b expected 0", cyc, out_valid);
      end
    end
    // Out-of-range address must not touch any tap; then a write coincident
    // with an accept must apply to that very sample.
    got.delete();
    tick(0, 0, 0, 1, 12, 99);
    for (int i = 0; i < 12; i++) begin
      tick(i == 0, 2, 0, i == 0, 0, 7);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL coef_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== 16'(exp_d)) begin
          errors++;
          $display("FAIL coef_data cyc=%0d out_data=%0d expected %0d", cyc, out_data, exp_d);
        end
      end
      if (out_valid === 1'b1) got.push_back(int'(out_data));
    end
    checks++;
    if (got.size() != 1 || got[0] != 14) begin
      errors++;
      $display("FAIL coef_race count=%0d first=%0d expected 1 result of 14", got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < TAPS; k++) tick(0, 0, 0, 1, k, int'($urandom_range(0, 255)));
    for (int i = 0; i < 408; i++) begin
      bit v;
      bit c;
      bit we;
      v  = (i < 400) && ($urandom_range(0, 3) != 0);
      c  = (i < 400) && ($urandom_range(0, 39) == 0);
      we = (i < 400) && ($urandom_range(0, 7) == 0);
      tick(v, int'($urandom_range(0, 255)), c, we, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL random_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== 16'(exp_d)) begin
          errors++;
          $display("FAIL random_data cyc=%0d out_data=%0d expected %0d", cyc, out_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < TAPS; k++) tick(0, 0, 0, 1, k, k + 1);
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, int'($urandom_range(1, 255)), 0, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL midrst_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
    end
    // Mid-cycle, between edges: the reset must clear the outputs without a clock.
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async out_valid=%b out_data=%0d expected 0/0", out_valid, out_data);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 18; i++) begin
      tick(i < 10, (i == 0) ? 1 : 0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL midrst_impulse_valid cyc=%0d out_valid=%b expected %b", cyc, out_valid, exp_v);
      end
      if (out_valid === 1'b1) got.push_back(int'(out_data));
    end
    checks++;
    if (got.size() != 10 || got.sum() != 0) begin
      errors++;
      $display("FAIL midrst_coef_cleared count=%0d sum=%0d expected 10 zero results", got.size(), got.sum());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    model_reset();
    #12;
    test_reset();
    test_impulse();
    test_moving_sum(1'b0);
    test_moving_sum(1'b1);
    test_overflow();
    test_clr_coef();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
